axilite_regbank: RTL and testbench

- Parametrised AXI4-Lite register-bank slave; successor to the fixed 4-register AXI-Lite slave.
- Register count, data width and reset value are generic.
- Adds per-byte write strobes, read-only registers sourced from fabric inputs, per-register write pulses, and SLVERR on bad accesses.
- Sits between the AXI-Lite interconnect and a peripheral core (GPIO, timers), exporting control registers and importing status.

---
 rtl/axilite_regbank_if.sv | 38 +++
 rtl/axilite_regbank.sv | 150 +++++++++++++++
 tb/tb_axilite_regbank.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axilite_regbank_if.sv
// AXI4-Lite slave channel bundle for axilite_regbank.
// Clock and reset stay outside the bundle as plain ports.
interface axilite_regbank_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr;
    logic                              awvalid;
    logic                              awready;
    logic [2:0]                        awport;
    logic [C_S_AXI_DATA_WIDTH-1:0]     wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb;
    logic                              wvalid;
    logic                              wready;
    logic [1:0]                        bresp;
    logic                              bvalid;
    logic                              bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     araddr;
    logic                              arvalid;
    logic                              arready;
    logic [2:0]                        arport;
    logic [C_S_AXI_DATA_WIDTH-1:0]     rdata;
    logic [1:0]                        rresp;
    logic                              rvalid;
    logic                              rready;

    modport slave (
        input  awaddr, awvalid, awport, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, arport, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, awport, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, arport, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axilite_regbank.sv
// Parametrised AXI4-Lite register bank: byte-strobed writes, fabric-sourced
// read-only registers, per-register write pulses and SLVERR on bad accesses.
module axilite_regbank #(
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_S_AXI_ADDR_WIDTH = 6,
    parameter int                            NUM_REGS           = 8,
    parameter logic [NUM_REGS-1:0]           RO_MASK            = '0,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] RST_VAL            = '0
) (
    input  logic                                   s_axi_aclk,
    input  logic                                   s_axi_aresetn,
    axilite_regbank_if.slave                       s_axi,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]                    wr_pulse
);
    localparam int DATA_W = C_S_AXI_DATA_WIDTH;
    localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int NB     = DATA_W / 8;
    localparam int OFS    = $clog2(NB);
    localparam int IDX_W  = ADDR_W - OFS;
    localparam int SLOTS  = 1 << IDX_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [NB-1:0]     strb
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int k = 0; k < NB; k++) begin
            if (strb[k]) res[k*8 +: 8] = new_val[k*8 +: 8];
        end
        return res;
    endfunction

    logic              rst_done;
    logic              aw_held;
    logic              w_held;
    logic [IDX_W-1:0]  aw_idx;
    logic [DATA_W-1:0] w_data;
    logic [NB-1:0]     w_strb;

    logic [DATA_W-1:0] slot_val [SLOTS];
    logic [SLOTS-1:0]  slot_ok;
    logic [SLOTS-1:0]  slot_ro;
    logic [SLOTS-1:0]  wr_hit;

    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             commit;
    logic             wr_err;
    logic [IDX_W-1:0] ar_idx;

    assign s_axi.awready = rst_done & ~aw_held & ~s_axi.bvalid;
    assign s_axi.wready  = rst_done & ~w_held & ~s_axi.bvalid;
    assign s_axi.arready = rst_done & ~s_axi.rvalid;

    assign aw_hs  = s_axi.awvalid & s_axi.awready;
    assign w_hs   = s_axi.wvalid & s_axi.wready;
    assign ar_hs  = s_axi.arvalid & s_axi.arready;
    assign ar_idx = s_axi.araddr[ADDR_W-1:OFS];

    // A write commits on the edge after both address and data are held.
    assign commit = aw_held & w_held;
    assign wr_err = ~slot_ok[aw_idx] | slot_ro[aw_idx];
    assign wr_hit = (commit & ~wr_err) ? (SLOTS'(1) << aw_idx) : '0;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rst_done     <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx       <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            wr_pulse     <= '0;
            s_axi.bvalid <= 1'b0;
            s_axi.bresp  <= RESP_OKAY;
            s_axi.rvalid <= 1'b0;
            s_axi.rresp  <= RESP_OKAY;
            s_axi.rdata  <= '0;
        end else begin
            rst_done <= 1'b1;
            wr_pulse <= wr_hit[NUM_REGS-1:0];

            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axi.awaddr[ADDR_W-1:OFS];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_axi.wdata;
                w_strb <= s_axi.wstrb;
            end

            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi.bvalid <= 1'b1;
                s_axi.bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi.bvalid && s_axi.bready) begin
                s_axi.bvalid <= 1'b0;
            end

            // Read samples pre-commit storage, so a colliding write is not yet visible.
            if (ar_hs) begin
                s_axi.rvalid <= 1'b1;
                s_axi.rdata  <= slot_val[ar_idx];
                s_axi.rresp  <= slot_ok[ar_idx] ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi.rvalid && s_axi.rready) begin
                s_axi.rvalid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        if (i >= NUM_REGS) begin : g_none
            assign slot_val[i] = '0;
            assign slot_ok[i]  = 1'b0;
            assign slot_ro[i]  = 1'b0;
        end else if (RO_MASK[i]) begin : g_ro
            assign slot_val[i]                  = reg_in[i*DATA_W +: DATA_W];
            assign slot_ok[i]                   = 1'b1;
            assign slot_ro[i]                   = 1'b1;
            assign reg_out[i*DATA_W +: DATA_W]  = reg_in[i*DATA_W +: DATA_W];
        end else begin : g_rw
            logic [DATA_W-1:0] q;
            always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
                if (!s_axi_aresetn) begin
                    q <= RST_VAL;
                end else if (wr_hit[i]) begin
                    q <= merge_bytes(q, w_data, w_strb);
                end
            end
            assign slot_val[i]                  = q;
            assign slot_ok[i]                   = 1'b1;
            assign slot_ro[i]                   = 1'b0;
            assign reg_out[i*DATA_W +: DATA_W]  = q;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{reg_in, s_axi.awport, s_axi.arport,
                         s_axi.awaddr[OFS-1:0], s_axi.araddr[OFS-1:0], wr_hit};
endmodule

// File: tb/tb_axilite_regbank.sv
// Randomised bench for axilite_regbank against a transaction-level model of
// the register bank (register array + pending write + outstanding responses).
module tb_axilite_regbank;
    localparam int DW  = 32;
    localparam int AW  = 6;
    localparam int NR  = 8;
    localparam int TMO = 64;
    localparam logic [NR-1:0] RO = 8'h01;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR*DW-1:0]  reg_out;
    logic [NR*DW-1:0]  reg_in;
    logic [NR-1:0]     wr_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    axilite_regbank_if #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)) s_axi ();

    axilite_regbank #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR),
        .RO_MASK(RO),
        .RST_VAL('0)
    ) dut (
        .s_axi_aclk(clk),
        .s_axi_aresetn(rst_n),
        .s_axi(s_axi),
        .reg_out(reg_out),
        .reg_in(reg_in),
        .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [DW-1:0] m_reg [NR];
    logic          m_rst_done, m_aw_held, m_w_held, m_bvalid, m_rvalid;
    int            m_aw_idx;
    logic [DW-1:0] m_w_data, m_rdata;
    logic [3:0]    m_w_strb;
    logic [1:0]    m_bresp, m_rresp;
    logic [NR-1:0] m_pulse;
    int            aw_cnt = 0, w_cnt = 0;
    int            pulse_cnt [NR];

    function automatic void mdl_reset();
        for (int i = 0; i < NR; i++) m_reg[i] = '0;
        m_rst_done = 0; m_aw_held = 0; m_w_held = 0; m_bvalid = 0; m_rvalid = 0;
        m_bresp = 0; m_rresp = 0; m_rdata = 0; m_pulse = 0;
    endfunction

    function automatic logic [DW-1:0] mdl_view(input int i);
        return RO[i] ? reg_in[i*DW +: DW] : m_reg[i];
    endfunction

    function automatic void mdl_read(input int idx, output logic [DW-1:0] d, output logic [1:0] r);
        if (idx >= NR) begin
            d = '0; r = 2'b10;
        end else begin
            d = mdl_view(idx); r = 2'b00;
        end
    endfunction

    function automatic void mdl_write(input int idx, input logic [DW-1:0] d, input logic [3:0] s,
                                      output logic [1:0] r, output logic [NR-1:0] p);
        logic [DW-1:0] mask;
        p = '0;
        if (idx >= NR) begin
            r = 2'b10;
        end else if (RO[idx]) begin
            r = 2'b10;
        end else begin
            for (int k = 0; k < 4; k++) mask[k*8 +: 8] = {8{s[k]}};
            m_reg[idx] = (m_reg[idx] & ~mask) | (d & mask);
            p[idx] = 1'b1;
            r = 2'b00;
        end
    endfunction

    // Advance the model across the coming rising edge, using the handshakes presented to it.
    function automatic void mdl_step();
        logic aw_hs, w_hs, ar_hs;
        aw_hs = s_axi.awvalid && s_axi.awready;
        w_hs  = s_axi.wvalid && s_axi.wready;
        ar_hs = s_axi.arvalid && s_axi.arready;
        m_pulse = '0;
        if (m_bvalid && s_axi.bready) m_bvalid = 0;
        if (m_rvalid && s_axi.rready) m_rvalid = 0;
        if (ar_hs) begin
            mdl_read(int'(s_axi.araddr) / 4, m_rdata, m_rresp);
            m_rvalid = 1;
        end
        if (m_aw_held && m_w_held) begin
            mdl_write(m_aw_idx, m_w_data, m_w_strb, m_bresp, m_pulse);
            m_bvalid = 1; m_aw_held = 0; m_w_held = 0;
        end
        if (aw_hs) begin
            m_aw_held = 1; m_aw_idx = int'(s_axi.awaddr) / 4; aw_cnt++;
        end
        if (w_hs) begin
            m_w_held = 1; m_w_data = s_axi.wdata; m_w_strb = s_axi.wstrb; w_cnt++;
        end
        m_rst_done = 1;
    endfunction

    initial begin : monitor
        for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
        mdl_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) mdl_reset();
            check("awready", s_axi.awready, m_rst_done && !m_aw_held && !m_bvalid);
            check("wready", s_axi.wready, m_rst_done && !m_w_held && !m_bvalid);
            check("arready", s_axi.arready, m_rst_done && !m_rvalid);
            check("bvalid", s_axi.bvalid, m_bvalid);
            check("rvalid", s_axi.rvalid, m_rvalid);
            if (m_bvalid) check("bresp", s_axi.bresp, m_bresp);
            if (m_rvalid) begin
                check("rdata", s_axi.rdata, m_rdata);
                check("rresp", s_axi.rresp, m_rresp);
            end
            check("wr_pulse", wr_pulse, m_pulse);
            for (int i = 0; i < NR; i++) begin
                check("reg_out", reg_out[i*DW +: DW], mdl_view(i));
                if (wr_pulse[i]) pulse_cnt[i]++;
            end
            if (rst_n) mdl_step();
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run exceeded 500000 time units");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [AW-1:0] a);
        int n = 0;
        s_axi.awaddr = a; s_axi.awvalid = 1;
        while (!s_axi.awready && n < TMO) begin tick(); n++; end
        if (n >= TMO) check("aw_timeout", 1, 0);
        tick();
        s_axi.awvalid = 0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [3:0] s);
        int n = 0;
        s_axi.wdata = d; s_axi.wstrb = s; s_axi.wvalid = 1;
        while (!s_axi.wready && n < TMO) begin tick(); n++; end
        if (n >= TMO) check("w_timeout", 1, 0);
        tick();
        s_axi.wvalid = 0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                            input int lead, input int bdly, output logic [1:0] resp);
        int n = 0;
        fork
            send_w(d, s);
            begin
                repeat (lead) tick();
                send_aw(a);
            end
        join
        while (!s_axi.bvalid && n < TMO) begin tick(); n++; end
        if (n >= TMO) check("b_timeout", 1, 0);
        repeat (bdly) tick();
        resp = s_axi.bresp;
        s_axi.bready = 1;
        tick();
        s_axi.bready = 0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int rdly,
                           output logic [DW-1:0] d, output logic [1:0] r);
        int n = 0;
        s_axi.araddr = a; s_axi.arvalid = 1;
        while (!s_axi.arready && n < TMO) begin tick(); n++; end
        if (n >= TMO) check("ar_timeout", 1, 0);
        tick();
        s_axi.arvalid = 0;
        n = 0;
        while (!s_axi.rvalid && n < TMO) begin tick(); n++; end
        if (n >= TMO) check("r_timeout", 1, 0);
        repeat (rdly) tick();
        d = s_axi.rdata; r = s_axi.rresp;
        s_axi.rready = 1;
        tick();
        s_axi.rready = 0;
    endtask

    initial begin : main
        logic [1:0]    resp;
        logic [1:0]    r;
        logic [DW-1:0] d;
        int            a0, w0, psum;

        rst_n = 0;
        s_axi.awaddr = 0; s_axi.awvalid = 0; s_axi.awport = 0;
        s_axi.wdata = 0; s_axi.wstrb = 0; s_axi.wvalid = 0; s_axi.bready = 0;
        s_axi.araddr = 0; s_axi.arvalid = 0; s_axi.arport = 0; s_axi.rready = 0;
        reg_in[0 +: DW] = 32'hCAFE0001;
        for (int i = 1; i < NR; i++) reg_in[i*DW +: DW] = 32'h5A5A0000 + i;

        repeat (3) tick();
        rst_n = 1;
        check("rdy_at_release", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b000);
        tick();
        check("rdy_after_release", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b111);

        // Basic write then read back
        do_write(6'h08, 32'hDEADBEEF, 4'hF, 0, 0, resp);
        check("wr08_bresp", resp, 2'b00);
        check("wr08_pulse_cycles", pulse_cnt[2], 1);
        do_read(6'h08, 0, d, r);
        check("rd08_data", d, 32'hDEADBEEF);
        check("rd08_rresp", r, 2'b00);

        // Byte strobes
        do_write(6'h04, 32'h11223344, 4'hF, 0, 0, resp);
        do_write(6'h04, 32'hAABBCCDD, 4'h5, 0, 0, resp);
        check("strb_bresp", resp, 2'b00);
        do_read(6'h04, 0, d, r);
        check("strb_data", d, 32'h11BB33DD);

        // W presented three cycles ahead of AW
        a0 = aw_cnt; w0 = w_cnt;
        do_write(6'h04, 32'h01020304, 4'hF, 3, 0, resp);
        check("ooo_aw_hs", aw_cnt - a0, 1);
        check("ooo_w_hs", w_cnt - w0, 1);
        check("ooo_bresp", resp, 2'b00);

        // Out-of-range and read-only accesses
        psum = 0;
        for (int i = 0; i < NR; i++) psum += pulse_cnt[i];
        do_write(6'h20, 32'h12345678, 4'hF, 0, 0, resp);
        check("oor_bresp", resp, 2'b10);
        do_read(6'h20, 0, d, r);
        check("oor_rdata", d, 0);
        check("oor_rresp", r, 2'b10);
        do_write(6'h00, 32'h87654321, 4'hF, 1, 0, resp);
        check("ro_bresp", resp, 2'b10);
        a0 = 0;
        for (int i = 0; i < NR; i++) a0 += pulse_cnt[i];
        check("err_no_pulse", a0 - psum, 0);
        do_read(6'h00, 0, d, r);
        check("ro_rdata", d, 32'hCAFE0001);
        check("ro_rresp", r, 2'b00);

        // Zero strobe to an RW register still pulses, data unchanged
        psum = pulse_cnt[5];
        do_write(6'h14, 32'hFFFFFFFF, 4'h0, 0, 0, resp);
        check("strb0_bresp", resp, 2'b00);
        check("strb0_pulse", pulse_cnt[5] - psum, 1);
        check("strb0_reg", reg_out[5*DW +: DW], 0);

        // Back-pressure on both response channels, low address bits ignored
        do_write(6'h0F, 32'h600DCAFE, 4'hF, 0, 5, resp);
        check("bp_bresp", resp, 2'b00);
        do_read(6'h0D, 5, d, r);
        check("bp_rdata", d, 32'h600DCAFE);

        // Concurrent random writes and reads
        fork
            begin : writer
                logic [1:0] wr_rsp;
                for (int i = 0; i < 50; i++) begin
                    do_write(AW'($urandom_range(0, 3) * 4), DW'($urandom_range(0, 16'hFFFF)), 4'hF,
                             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), wr_rsp);
                end
            end
            begin : reader
                logic [DW-1:0] rd_d;
                logic [1:0]    rd_r;
                for (int i = 0; i < 50; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    do_read(AW'($urandom_range(0, 3) * 4), int'($urandom_range(0, 2)), rd_d, rd_r);
                end
            end
        join

        // Reset while an address is held without data
        send_aw(6'h08);
        rst_n = 0;
        tick();
        check("rst_bvalid_low", s_axi.bvalid, 0);
        tick();
        rst_n = 1;
        repeat (6) begin
            tick();
            check("rst_no_bvalid", s_axi.bvalid, 0);
        end
        for (int i = 1; i < NR; i++) check("rst_regs", reg_out[i*DW +: DW], 0);
        do_read(6'h08, 0, d, r);
        check("rst_rd08", d, 0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
